// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default frame constants
package uart_pkg;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser resetting to 1 for an idle-high serial line
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with mid-bit sampling and valid/ready output
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  logic                 w_rx_s;
  logic                 w_mid_bit;
  logic                 w_end_bit;
  rx_state_t            r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par_bad;
  logic                 r_done;
  logic                 r_stop;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_overrun;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (rx_i),
    .o_sync  (w_rx_s)
  );

  assign w_mid_bit = (r_cnt == CW'(OVERSAMPLE/2 - 1));
  assign w_end_bit = (r_cnt == CW'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_par_bad <= 1'b0;
      r_done    <= 1'b0;
      r_stop    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (w_mid_bit) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_bit_idx <= '0;
              r_state   <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_end_bit) begin
            r_cnt     <= '0;
            r_shreg   <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == IW'(DATA_BITS - 1))
              r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_end_bit) begin
            r_cnt     <= '0;
            r_par_bad <= (^r_shreg) ^ w_rx_s ^ (PARITY_ODD != 0);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed
          if (w_end_bit) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_stop  <= w_rx_s;
            r_state <= w_rx_s ? S_IDLE : S_BREAK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_valid || ready_i) begin
          r_data       <= r_shreg;
          r_frame_err  <= !r_stop;
          r_parity_err <= r_par_bad;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid      <= 1'b0;
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
      end
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign frame_err_o  = r_frame_err;
  assign parity_err_o = r_parity_err;
  assign overrun_o    = r_overrun;
  assign busy_o       = (r_state != S_IDLE);

endmodule
